// File: rtl/fixed_point_converter.sv
// fixed_point_converter: two-stage fixed-point format converter with rounding, saturation/wrap and overflow statistics.
module fixed_point_converter #(
  parameter int inputBitSize   = 16,
  parameter int inputFracSize  = 8,
  parameter int outputBitSize  = 8,
  parameter int outputFracSize = 4,
  parameter int isSigned       = 1,
  parameter int roundMode      = 1,
  parameter int saturate       = 1,
  parameter int countWidth     = 16
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [inputBitSize-1:0]  in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [outputBitSize-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_overflow,
  output logic                     overflow_sticky,
  output logic [countWidth-1:0]    sat_count,
  input  logic                     clear_stats
);
  // Internal width is generous enough that alignment and the rounding add never lose bits.
  localparam int W  = inputBitSize + outputBitSize + outputFracSize + 2;
  localparam int SH = inputFracSize - outputFracSize;
  localparam logic signed [W-1:0] MAX_V = (isSigned != 0) ? (W'(1) << (outputBitSize - 1)) - W'(1)
                                                          : (W'(1) << outputBitSize) - W'(1);
  localparam logic signed [W-1:0] MIN_V = (isSigned != 0) ? -(W'(1) << (outputBitSize - 1)) : '0;
  logic signed [W-1:0] ext, aligned, a1_q;
  logic v1_q, out_valid_q, ovf_q, sticky_q, sticky_d, advance, hi, lo, ovf, ev;
  logic [outputBitSize-1:0] out_data_q, out_data_d;
  logic [countWidth-1:0] cnt_q, cnt_d;
  assign ext = {{(W-inputBitSize){isSigned != 0 && in_data[inputBitSize-1]}}, in_data};
  if (SH > 0) begin : g_rnd
    localparam logic signed [W-1:0] HALF = (roundMode != 0) ? W'(1) << (SH - 1) : '0;
    assign aligned = (ext + HALF) >>> SH;
  end else begin : g_ext
    assign aligned = ext <<< (-SH);
  end
  assign advance = !out_valid_q || out_ready;
  assign in_ready = advance;
  always_comb begin
    hi = a1_q > MAX_V;
    lo = a1_q < MIN_V;
    ovf = hi || lo;
    out_data_d = (saturate == 0) ? a1_q[outputBitSize-1:0]
               : hi ? MAX_V[outputBitSize-1:0]
               : lo ? MIN_V[outputBitSize-1:0] : a1_q[outputBitSize-1:0];
    ev = advance && v1_q && ovf;
    cnt_d = clear_stats ? '0 : (ev && cnt_q != '1) ? cnt_q + countWidth'(1) : cnt_q;
    sticky_d = clear_stats ? 1'b0 : sticky_q || ev;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q        <= 1'b0;
      a1_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (advance) begin
        v1_q        <= in_valid;
        a1_q        <= aligned;
        out_valid_q <= v1_q;
        out_data_q  <= out_data_d;
        ovf_q       <= v1_q && ovf;
      end
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end
  assign out_data        = out_data_q;
  assign out_valid       = out_valid_q;
  assign out_overflow    = ovf_q;
  assign overflow_sticky = sticky_q;
  assign sat_count       = cnt_q;
endmodule

// File: tb/tb_fixed_point_converter.sv
// tb_fixed_point_converter: directed vectors for a saturating Q8.8->Q4.4 converter and a wrapping one with a 2-bit counter.
module tb_fixed_point_converter;
  logic clk = 1'b0, reset, in_valid, out_ready, clear_stats;
  logic [15:0] in_data;
  logic s_in_ready, s_out_valid, s_out_overflow, s_sticky;
  logic w_in_ready, w_out_valid, w_out_overflow, w_sticky;
  logic [7:0] s_out_data, w_out_data;
  logic [15:0] s_sat_count;
  logic [1:0] w_sat_count;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  fixed_point_converter u_sat (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_overflow(s_out_overflow),
    .overflow_sticky(s_sticky), .sat_count(s_sat_count), .clear_stats(clear_stats)
  );
  fixed_point_converter #(.saturate(0), .countWidth(2)) u_wrap (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(w_in_ready),
    .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(out_ready), .out_overflow(w_out_overflow),
    .overflow_sticky(w_sticky), .sat_count(w_sat_count), .clear_stats(clear_stats)
  );
  typedef struct {
    logic [15:0] din;
    logic [7:0]  sat;
    logic        ov;
    logic [7:0]  wrp;
  } vec_t;
  vec_t tbl[12];
  logic [7:0] got[$];
  bit rec = 0;
  always @(negedge clk) if (rec && s_out_valid && out_ready) got.push_back(s_out_data);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] bp_in[3];
    logic [7:0] bp_out[3];
    int j;
    tbl[0]  = '{16'h0350, 8'h35, 1'b0, 8'h35};
    tbl[1]  = '{16'h0358, 8'h36, 1'b0, 8'h36};
    tbl[2]  = '{16'hFFF8, 8'h00, 1'b0, 8'h00};
    tbl[3]  = '{16'h0900, 8'h7F, 1'b1, 8'h90};
    tbl[4]  = '{16'hF000, 8'h80, 1'b1, 8'h00};
    tbl[5]  = '{16'h07F8, 8'h7F, 1'b1, 8'h80};
    tbl[6]  = '{16'hFFF7, 8'hFF, 1'b0, 8'hFF};
    tbl[7]  = '{16'hF800, 8'h80, 1'b0, 8'h80};
    tbl[8]  = '{16'hF7F8, 8'h80, 1'b0, 8'h80};
    tbl[9]  = '{16'hF7F7, 8'h80, 1'b1, 8'h7F};
    tbl[10] = '{16'h07F7, 8'h7F, 1'b0, 8'h7F};
    tbl[11] = '{16'h8000, 8'h80, 1'b1, 8'h00};
    bp_in  = '{16'h0100, 16'h0200, 16'h0300};
    bp_out = '{8'h10, 8'h20, 8'h30};
    reset = 1; in_valid = 0; in_data = 0; out_ready = 1; clear_stats = 0;
    repeat (3) step();
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_out_data", s_out_data, 0);
    chk("rst_out_overflow", s_out_overflow, 0);
    chk("rst_sticky", s_sticky, 0);
    chk("rst_sat_count", s_sat_count, 0);
    reset = 0;
    chk("rst_in_ready", s_in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      in_data = tbl[i].din; in_valid = 1;
      step();
      in_valid = 0;
      step();
      chk($sformatf("vec%0d_valid", i), s_out_valid, 1);
      chk($sformatf("vec%0d_sat_data", i), s_out_data, tbl[i].sat);
      chk($sformatf("vec%0d_sat_ovf", i), s_out_overflow, tbl[i].ov);
      chk($sformatf("vec%0d_wrap_data", i), w_out_data, tbl[i].wrp);
      chk($sformatf("vec%0d_wrap_ovf", i), w_out_overflow, tbl[i].ov);
      if (i == 5) begin
        chk("three_ovf_count", s_sat_count, 3);
        chk("three_ovf_sticky", s_sticky, 1);
      end
      step();
      chk($sformatf("vec%0d_bubble", i), s_out_valid, 0);
    end
    chk("sat_count_total", s_sat_count, 5);
    chk("sticky_total", s_sticky, 1);
    chk("wrap_count_held", w_sat_count, 3);
    chk("wrap_sticky", w_sticky, 1);
    in_data = 16'h0900; in_valid = 1;
    step();
    in_valid = 0; clear_stats = 1;
    step();
    clear_stats = 0;
    chk("clr_ovf_out", s_out_overflow, 1);
    chk("clr_count", s_sat_count, 0);
    chk("clr_sticky", s_sticky, 0);
    chk("clr_wrap_count", w_sat_count, 0);
    chk("clr_wrap_sticky", w_sticky, 0);
    step();
    chk("clr_count_after", s_sat_count, 0);
    out_ready = 0; in_data = 16'h0900; in_valid = 1;
    step();
    in_valid = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_valid", s_out_valid, 1);
      chk("stall_data", s_out_data, 8'h7F);
      chk("stall_count", s_sat_count, 1);
    end
    out_ready = 1;
    step();
    chk("stall_release_valid", s_out_valid, 0);
    chk("stall_release_count", s_sat_count, 1);
    rec = 1; j = 0;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 2 && c < 5);
      in_valid = j < 3;
      in_data = (j < 3) ? bp_in[j] : 16'h0;
      @(negedge clk);
      if (c >= 2 && c < 5) begin
        chk("bp_stall_valid", s_out_valid, 1);
        chk("bp_stall_data", s_out_data, 8'h10);
        chk("bp_in_ready_low", s_in_ready, 0);
      end
      if (in_valid && s_in_ready) j++;
      step();
    end
    in_valid = 0; rec = 0;
    chk("bp_accepted", j, 3);
    chk("bp_count", got.size(), 3);
    for (int k = 0; k < 3; k++) chk($sformatf("bp_out%0d", k), (k < got.size()) ? got[k] : 8'hXX, bp_out[k]);
    in_data = 16'h0100; in_valid = 1;
    step();
    in_data = 16'h0200;
    step();
    chk("mid_inflight_valid", s_out_valid, 1);
    reset = 1; in_valid = 0;
    step();
    chk("mid_rst_valid", s_out_valid, 0);
    chk("mid_rst_data", s_out_data, 0);
    chk("mid_rst_count", s_sat_count, 0);
    reset = 0;
    chk("mid_rst_in_ready", s_in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_rst_no_stale", s_out_valid, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
